sync_fifo_ctrl: RTL
===================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock, parametrised FIFO; next generation of our FIFO family for same-domain buffering.
//  Adds over the dual-clock version: exact fill level, programmable almost-full/almost-empty flags,
//  sticky overflow/underflow errors, and a compile-time first-word-fall-through (FWFT) read mode.
// PARAMETERS
//  DATA_WIDTH  16   word width in bits
//  DEPTH       16   number of entries; power of two, >= 4
//  ADDR_WIDTH  4    log2(DEPTH); pointers are ADDR_WIDTH+1 bits (extra wrap bit)
//  AF_THRESH   12   almost_full asserted when level >= AF_THRESH (1..DEPTH)
//  AE_THRESH   4    almost_empty asserted when level <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1             single clock, all logic on rising edge
//  rst           in   1             reset, synchronous, active-high
//  wr_en         in   1             write request
//  data_in       in   DATA_WIDTH    write data
//  rd_en         in   1             read request (FWFT: pop/acknowledge of data_out)
//  data_out      out  DATA_WIDTH    read data
//  data_valid    out  1             data_out holds a valid popped/head word
//  fifo_full     out  1             level == DEPTH
//  fifo_empty    out  1             no word available to read
//  almost_full   out  1             level >= AF_THRESH
//  almost_empty  out  1             level <= AE_THRESH
//  level         out  ADDR_WIDTH+1  words held (0..DEPTH)
//  overflow      out  1             sticky: write rejected because full
//  underflow     out  1             sticky: read rejected because empty
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): pointers, level=0, data_out=0, data_valid=0, overflow=underflow=0,
//    fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0. Mid-operation reset discards contents;
//    memory array is not cleared. Requests in the reset cycle are ignored.
//  - rd_ok = rd_en & ~fifo_empty; wr_ok = wr_en & (~fifo_full | rd_ok).
//  - Write when full with simultaneous accepted read: both accepted, level unchanged.
//  - Read when empty with simultaneous write: read rejected (underflow set), write accepted.
//  - Rejected write: no state change except overflow<=1. Rejected read: underflow<=1.
//  - Sticky flags clear only on rst.
//  - level: +1 on wr_ok only, -1 on rd_ok only, unchanged on both/neither; registered.
//  - All status flags decoded from registered level/pointers; update the cycle after the op.
//  - Pointers wrap at DEPTH; wrap bit distinguishes full from empty; full<->empty never inconsistent.
//  - Standard mode: rd_ok at edge N -> data_out updated and data_valid=1 after edge N+1 (1-cycle
//    latency); data_valid=0 in cycles with no rd_ok; data_out holds last value.
// CONFIGURATION
//  SYNC_FIFO_FWFT_EN defined: output register prefetches head word; data_valid=1 whenever a word is
//    presented, fifo_empty = ~data_valid; rd_en with data_valid pops and presents next word the same
//    edge if one is stored. Write into empty FIFO -> data_valid=1 one cycle later. level counts the
//    output-register word. rd_en with data_valid=0 sets underflow.
//  Not defined: standard mode above; no prefetch logic synthesised.
// STRUCTURE
//  - sync_fifo_pkg: ptr/level widths as localparams, function clog2, status struct typedef
//    {full, empty, almost_full, almost_empty}.
//  - One sub-module: sync_fifo_ram (simple dual-port, sync write, registered read, DATA_WIDTH x DEPTH).
//  - Top holds pointer/level counters, flag decode, sticky errors, FWFT prefetch stage.
// TESTING (DATA_WIDTH=16, DEPTH=16, AF=12, AE=4)
//  - Write 0x0000..0x000F then read 16 -> same order, full=1 after 16th write, empty=1 after last read.
//  - 17th write 0xDEAD when full -> rejected, overflow=1, level=16, 0xDEAD never read out.
//  - rd_en on empty after reset -> underflow=1, data_valid=0, level=0.
//  - Full + simultaneous wr/rd for 40 cycles -> level stays 16, data order intact across wrap.
//  - Fill to 4/5/11/12 -> almost_empty 1/0, almost_full 0/1 at the stated levels.
//  - rst mid-stream at level=7 -> next cycle level=0, empty=1, flags cleared; FWFT build:
//    single write 0x1234 -> data_valid=1, data_out=0x1234 one cycle later without rd_en.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared widths, helper function and status struct for the single-clock FIFO family.
// Pointers and level carry one extra bit so that a full FIFO can be told apart from an empty one.
package sync_fifo_pkg;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int P_DATA_WIDTH  = 16;
    localparam int P_DEPTH       = 16;
    localparam int P_ADDR_WIDTH  = clog2(P_DEPTH);
    localparam int P_PTR_WIDTH   = P_ADDR_WIDTH + 1;
    localparam int P_LEVEL_WIDTH = P_ADDR_WIDTH + 1;
    localparam int P_AF_THRESH   = 12;
    localparam int P_AE_THRESH   = 4;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read that holds its value when not read.
// Only the read register is reset; the array keeps whatever it held.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-before-write: a same-edge write to the read address is not seen here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, exact level, threshold flags, sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise reads have 1-cycle latency.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = P_DATA_WIDTH,
    parameter int DEPTH      = P_DEPTH,
    parameter int ADDR_WIDTH = P_ADDR_WIDTH,
    parameter int AF_THRESH  = P_AF_THRESH,
    parameter int AE_THRESH  = P_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] LP_AF  = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LP_AE  = AE_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LP_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [ADDR_WIDTH:0]   w_rd_ptr_next;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [ADDR_WIDTH-1:0] w_ram_raddr;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    fifo_status_t          w_status;

    // Full/empty come from the pointers (wrap bit decides); thresholds from the level counter.
    always_comb begin
        w_status              = '0;
        w_status.empty        = (r_wr_ptr == r_rd_ptr);
        w_status.full         = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                                (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
        w_status.almost_full  = (r_level >= LP_AF);
        w_status.almost_empty = (r_level <= LP_AE);
    end

    assign w_rd_ok       = rd_en & ~w_status.empty;
    assign w_wr_ok       = wr_en & (~w_status.full | w_rd_ok);
    assign w_ram_we      = w_wr_ok & ~rst;
    assign w_rd_ptr_next = w_rd_ok ? (r_rd_ptr + LP_ONE) : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + LP_ONE;
            end
            r_rd_ptr <= w_rd_ptr_next;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + LP_ONE;
                2'b01:   r_level <= r_level - LP_ONE;
                default: r_level <= r_level;
            endcase
            if (wr_en && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The RAM read register always tracks the head-to-be; a write landing on that
    // address in the same edge is caught by the bypass register instead.
    logic                  r_byp_valid;
    logic [DATA_WIDTH-1:0] r_byp_data;

    assign w_ram_re    = 1'b1;
    assign w_ram_raddr = w_rd_ptr_next[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_valid <= 1'b0;
            r_byp_data  <= '0;
        end else begin
            r_byp_valid <= w_ram_we && (r_wr_ptr[ADDR_WIDTH-1:0] == w_rd_ptr_next[ADDR_WIDTH-1:0]);
            r_byp_data  <= data_in;
        end
    end

    assign data_out   = r_byp_valid ? r_byp_data : w_ram_rdata;
    assign data_valid = ~w_status.empty;
    assign fifo_empty = ~data_valid;
`else
    logic r_data_valid;

    assign w_ram_re    = w_rd_ok;
    assign w_ram_raddr = r_rd_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_ok;
        end
    end

    assign data_out   = w_ram_rdata;
    assign data_valid = r_data_valid;
    assign fifo_empty = w_status.empty;
`endif

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (data_in),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign fifo_full    = w_status.full;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
